// File: rtl/sctag_vd_array_ctl_if.sv
// Datapath <-> VD array responder bus for the L2 tag VUAD valid/dirty array.
// Optional build macro: VD_ARRAY_ERR_INJ_EN (adds err_inj_c4).
interface sctag_vd_array_ctl_if #(
   parameter int IDX_W     = 5,
   parameter int ERR_CNT_W = 8
);
   logic                 init_done;
   logic                 rd_en_c0;
   logic [IDX_W-1:0]     rd_idx_c0;
   logic [25:0]          vuad_array_rd_data_c1;
   logic                 rd_vld_c1;
   logic                 wr_en_c4;
   logic [IDX_W-1:0]     wr_idx_c4;
   logic [25:0]          vuad_array_wr_data_c4;
   logic                 valid_par_err_c1;
   logic                 dirty_par_err_c1;
   logic                 err_cnt_clr;
   logic [ERR_CNT_W-1:0] par_err_cnt;
`ifdef VD_ARRAY_ERR_INJ_EN
   logic                 err_inj_c4;

   modport master (
      output rd_en_c0, rd_idx_c0, wr_en_c4, wr_idx_c4, vuad_array_wr_data_c4,
             err_cnt_clr, err_inj_c4,
      input  init_done, vuad_array_rd_data_c1, rd_vld_c1, valid_par_err_c1,
             dirty_par_err_c1, par_err_cnt
   );
   modport slave (
      input  rd_en_c0, rd_idx_c0, wr_en_c4, wr_idx_c4, vuad_array_wr_data_c4,
             err_cnt_clr, err_inj_c4,
      output init_done, vuad_array_rd_data_c1, rd_vld_c1, valid_par_err_c1,
             dirty_par_err_c1, par_err_cnt
   );
`else
   modport master (
      output rd_en_c0, rd_idx_c0, wr_en_c4, wr_idx_c4, vuad_array_wr_data_c4,
             err_cnt_clr,
      input  init_done, vuad_array_rd_data_c1, rd_vld_c1, valid_par_err_c1,
             dirty_par_err_c1, par_err_cnt
   );
   modport slave (
      input  rd_en_c0, rd_idx_c0, wr_en_c4, wr_idx_c4, vuad_array_wr_data_c4,
             err_cnt_clr,
      output init_done, vuad_array_rd_data_c1, rd_vld_c1, valid_par_err_c1,
             dirty_par_err_c1, par_err_cnt
   );
`endif
endinterface

// File: rtl/sctag_vd_array_ctl.sv
// VD array responder: post-reset clear walk, C4 writes, C1 reads with write-first bypass,
// even-parity checking and a saturating error count. Optional macro: VD_ARRAY_ERR_INJ_EN.
module sctag_vd_array_ctl #(
   parameter int IDX_W     = 5,
   parameter int ERR_CNT_W = 8
) (
   input logic                 rclk,
   input logic                 arst,
   sctag_vd_array_ctl_if.slave bus
);
   localparam int                   DEPTH     = 1 << IDX_W;
   localparam logic [IDX_W-1:0]     IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0]     IDX_LAST  = {IDX_W{1'b1}};
   localparam logic [ERR_CNT_W-1:0] CNT_ONE   = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_CNT_W-1:0] CNT_MAX   = {ERR_CNT_W{1'b1}};

   typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   function automatic logic par_err_f(input logic [11:0] field, input logic par);
      return (^field) != par;
   endfunction

   state_t               r_state;
   logic [IDX_W-1:0]     r_walk_cnt;
   logic                 r_init_done;
   logic [25:0]          r_rd_data;
   logic                 r_rd_vld;
   logic                 r_v_err;
   logic                 r_d_err;
   logic [ERR_CNT_W-1:0] r_err_cnt;
   logic [25:0]          r_mem [DEPTH];

   logic                 w_byp_hit;
   logic [25:0]          w_wr_data;
   logic [25:0]          w_rd_data;
   logic                 w_mem_we;
   logic [IDX_W-1:0]     w_mem_idx;
   logic [25:0]          w_mem_wdata;

   // write data (with optional valid-parity inversion), bypass and array write port muxing
   always_comb begin
      w_wr_data   = bus.vuad_array_wr_data_c4;
`ifdef VD_ARRAY_ERR_INJ_EN
      w_wr_data[25] = bus.vuad_array_wr_data_c4[25] ^ bus.err_inj_c4;
`endif
      w_byp_hit   = bus.rd_en_c0 && bus.wr_en_c4 && (bus.rd_idx_c0 == bus.wr_idx_c4);
      w_rd_data   = w_byp_hit ? w_wr_data : r_mem[bus.rd_idx_c0];
      w_mem_we    = 1'b0;
      w_mem_idx   = bus.wr_idx_c4;
      w_mem_wdata = w_wr_data;
      if (r_state == ST_INIT) begin
         w_mem_we    = 1'b1;
         w_mem_idx   = r_walk_cnt;
         w_mem_wdata = 26'd0;
      end else begin
         w_mem_we    = bus.wr_en_c4;
      end
   end

   // array storage: no reset, cleared only by the init walk
   always_ff @(posedge rclk) begin
      if (w_mem_we) begin
         r_mem[w_mem_idx] <= w_mem_wdata;
      end
   end

   // control FSM with registered read data and parity flags
   always_ff @(posedge rclk or posedge arst) begin
      if (arst) begin
         r_state     <= ST_INIT;
         r_walk_cnt  <= {IDX_W{1'b0}};
         r_init_done <= 1'b0;
         r_rd_data   <= 26'd0;
         r_rd_vld    <= 1'b0;
         r_v_err     <= 1'b0;
         r_d_err     <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_walk_cnt <= r_walk_cnt + IDX_ONE;
               r_rd_vld   <= 1'b0;
               r_v_err    <= 1'b0;
               r_d_err    <= 1'b0;
               if (r_walk_cnt == IDX_LAST) begin
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
               end else begin
                  r_state     <= ST_INIT;
               end
            end
            ST_RUN: begin
               r_rd_vld <= bus.rd_en_c0;
               if (bus.rd_en_c0) begin
                  r_rd_data <= w_rd_data;
                  r_v_err   <= par_err_f(w_rd_data[24:13], w_rd_data[25]);
                  r_d_err   <= par_err_f(w_rd_data[11:0], w_rd_data[12]);
               end else begin
                  r_v_err   <= 1'b0;
                  r_d_err   <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_INIT;
               r_walk_cnt <= {IDX_W{1'b0}};
            end
         endcase
      end
   end

   // saturating error count; a double error in one cycle counts once, clear has priority
   always_ff @(posedge rclk or posedge arst) begin
      if (arst) begin
         r_err_cnt <= {ERR_CNT_W{1'b0}};
      end else if (bus.err_cnt_clr) begin
         r_err_cnt <= {ERR_CNT_W{1'b0}};
      end else if ((r_v_err || r_d_err) && (r_err_cnt != CNT_MAX)) begin
         r_err_cnt <= r_err_cnt + CNT_ONE;
      end else begin
         r_err_cnt <= r_err_cnt;
      end
   end

   assign bus.init_done             = r_init_done;
   assign bus.vuad_array_rd_data_c1 = r_rd_data;
   assign bus.rd_vld_c1             = r_rd_vld;
   assign bus.valid_par_err_c1      = r_v_err;
   assign bus.dirty_par_err_c1      = r_d_err;
   assign bus.par_err_cnt           = r_err_cnt;
endmodule

// File: tb/tb_sctag_vd_array_ctl.sv
// Directed bench for sctag_vd_array_ctl (IDX_W=5, ERR_CNT_W=8); covers VD_ARRAY_ERR_INJ_EN when defined.
module tb_sctag_vd_array_ctl;
   logic rclk;
   logic arst;
   int   n_tests;
   int   n_fail;

   sctag_vd_array_ctl_if #(.IDX_W(5), .ERR_CNT_W(8)) bus ();

   sctag_vd_array_ctl #(.IDX_W(5), .ERR_CNT_W(8)) dut (
      .rclk (rclk),
      .arst (arst),
      .bus  (bus)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   task automatic step();
      @(posedge rclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      arst = 1'b1;
      bus.rd_en_c0 = 1'b0;
      bus.rd_idx_c0 = 5'd0;
      bus.wr_en_c4 = 1'b0;
      bus.wr_idx_c4 = 5'd0;
      bus.vuad_array_wr_data_c4 = 26'd0;
      bus.err_cnt_clr = 1'b0;
`ifdef VD_ARRAY_ERR_INJ_EN
      bus.err_inj_c4 = 1'b0;
`endif
      repeat (3) step();
      check("rst_init_done", 32'(bus.init_done), 32'd0);
      check("rst_rd_vld", 32'(bus.rd_vld_c1), 32'd0);
      check("rst_rd_data", 32'(bus.vuad_array_rd_data_c1), 32'd0);
      check("rst_verr", 32'(bus.valid_par_err_c1), 32'd0);
      check("rst_derr", 32'(bus.dirty_par_err_c1), 32'd0);
      check("rst_cnt", 32'(bus.par_err_cnt), 32'd0);

      // requests held high through the walk must be ignored
      bus.rd_en_c0 = 1'b1;
      bus.rd_idx_c0 = 5'd7;
      bus.wr_en_c4 = 1'b1;
      bus.wr_idx_c4 = 5'd7;
      bus.vuad_array_wr_data_c4 = 26'h3ffffff;
      arst = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         step();
         check("init_rd_vld", 32'(bus.rd_vld_c1), 32'd0);
         if (i < 32) check("init_done_low", 32'(bus.init_done), 32'd0);
         else        check("init_done_rise", 32'(bus.init_done), 32'd1);
      end
      bus.wr_en_c4 = 1'b0;
      for (int r = 0; r < 32; r++) begin
         bus.rd_idx_c0 = 5'(r);
         step();
         check("post_init_vld", 32'(bus.rd_vld_c1), 32'd1);
         check("post_init_data", 32'(bus.vuad_array_rd_data_c1), 32'd0);
         check("post_init_err", 32'({bus.valid_par_err_c1, bus.dirty_par_err_c1}), 32'd0);
      end
      bus.rd_en_c0 = 1'b0;
      step();
      check("idle_vld", 32'(bus.rd_vld_c1), 32'd0);
      check("idle_data_hold", 32'(bus.vuad_array_rd_data_c1), 32'd0);

      // write row 7, read it back
      bus.wr_en_c4 = 1'b1;
      bus.wr_idx_c4 = 5'd7;
      bus.vuad_array_wr_data_c4 = 26'h2002000;
      step();
      bus.wr_en_c4 = 1'b0;
      bus.rd_en_c0 = 1'b1;
      bus.rd_idx_c0 = 5'd7;
      step();
      check("wr_rd_vld", 32'(bus.rd_vld_c1), 32'd1);
      check("wr_rd_data", 32'(bus.vuad_array_rd_data_c1), 32'h2002000);
      check("wr_rd_err", 32'({bus.valid_par_err_c1, bus.dirty_par_err_c1}), 32'd0);

      // collision on row 3: bypass; valid field 12'h800 with parity 0 flags a valid error
      bus.rd_idx_c0 = 5'd3;
      bus.wr_en_c4 = 1'b1;
      bus.wr_idx_c4 = 5'd3;
      bus.vuad_array_wr_data_c4 = 26'h1001001;
      step();
      check("coll_data", 32'(bus.vuad_array_rd_data_c1), 32'h1001001);
      check("coll_verr", 32'(bus.valid_par_err_c1), 32'd1);
      check("coll_derr", 32'(bus.dirty_par_err_c1), 32'd0);
      bus.wr_en_c4 = 1'b0;
      bus.rd_en_c0 = 1'b0;
      step();
      check("coll_cnt", 32'(bus.par_err_cnt), 32'd1);
      check("coll_flags_clear", 32'({bus.valid_par_err_c1, bus.dirty_par_err_c1}), 32'd0);
      bus.err_cnt_clr = 1'b1;
      step();
      bus.err_cnt_clr = 1'b0;
      check("clr_cnt", 32'(bus.par_err_cnt), 32'd0);

      // single valid-parity error on row 4
      bus.wr_en_c4 = 1'b1;
      bus.wr_idx_c4 = 5'd4;
      bus.vuad_array_wr_data_c4 = 26'h0002000;
      step();
      bus.wr_en_c4 = 1'b0;
      bus.rd_en_c0 = 1'b1;
      bus.rd_idx_c0 = 5'd4;
      step();
      check("p1_verr", 32'(bus.valid_par_err_c1), 32'd1);
      check("p1_derr", 32'(bus.dirty_par_err_c1), 32'd0);
      check("p1_cnt_before", 32'(bus.par_err_cnt), 32'd0);
      bus.rd_en_c0 = 1'b0;
      step();
      check("p1_cnt_after", 32'(bus.par_err_cnt), 32'd1);

      // double error on row 5 counts once
      bus.wr_en_c4 = 1'b1;
      bus.wr_idx_c4 = 5'd5;
      bus.vuad_array_wr_data_c4 = 26'h0002001;
      step();
      bus.wr_en_c4 = 1'b0;
      bus.rd_en_c0 = 1'b1;
      bus.rd_idx_c0 = 5'd5;
      step();
      check("p2_flags", 32'({bus.valid_par_err_c1, bus.dirty_par_err_c1}), 32'd3);
      bus.rd_en_c0 = 1'b0;
      step();
      check("p2_cnt", 32'(bus.par_err_cnt), 32'd2);

      // 300 back-to-back erroneous reads saturate the count
      bus.rd_en_c0 = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (i == 100) check("sat_mid_cnt", 32'(bus.par_err_cnt), 32'd101);
      end
      check("sat_cnt", 32'(bus.par_err_cnt), 32'd255);
      bus.err_cnt_clr = 1'b1;
      step();
      bus.err_cnt_clr = 1'b0;
      check("clr_wins_cnt", 32'(bus.par_err_cnt), 32'd0);
      check("clr_wins_flags", 32'({bus.valid_par_err_c1, bus.dirty_par_err_c1}), 32'd3);
      step();
      check("post_clr_cnt", 32'(bus.par_err_cnt), 32'd1);
      bus.rd_en_c0 = 1'b0;
      step();
      step();
      check("hold_cnt", 32'(bus.par_err_cnt), 32'd2);
      check("hold_data", 32'(bus.vuad_array_rd_data_c1), 32'h0002001);

      // reset at walk_cnt=10; row 9 must be cleared again
      bus.wr_en_c4 = 1'b1;
      bus.wr_idx_c4 = 5'd9;
      bus.vuad_array_wr_data_c4 = 26'h2002000;
      step();
      bus.wr_en_c4 = 1'b0;
      arst = 1'b1;
      step();
      check("rst2_init_done", 32'(bus.init_done), 32'd0);
      check("rst2_cnt", 32'(bus.par_err_cnt), 32'd0);
      check("rst2_data", 32'(bus.vuad_array_rd_data_c1), 32'd0);
      arst = 1'b0;
      repeat (10) step();
      arst = 1'b1;
      step();
      arst = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         step();
         if (i < 32) check("rewalk_done_low", 32'(bus.init_done), 32'd0);
         else        check("rewalk_done_rise", 32'(bus.init_done), 32'd1);
      end
      bus.rd_en_c0 = 1'b1;
      for (int r = 0; r < 32; r++) begin
         bus.rd_idx_c0 = 5'(r);
         step();
         check("rewalk_data", 32'(bus.vuad_array_rd_data_c1), 32'd0);
         check("rewalk_err", 32'({bus.valid_par_err_c1, bus.dirty_par_err_c1}), 32'd0);
      end
      bus.rd_en_c0 = 1'b0;
      step();

`ifdef VD_ARRAY_ERR_INJ_EN
      bus.wr_en_c4 = 1'b1;
      bus.wr_idx_c4 = 5'd2;
      bus.vuad_array_wr_data_c4 = 26'h0;
      bus.err_inj_c4 = 1'b1;
      step();
      bus.wr_en_c4 = 1'b0;
      bus.err_inj_c4 = 1'b0;
      bus.rd_en_c0 = 1'b1;
      bus.rd_idx_c0 = 5'd2;
      step();
      check("inj_data", 32'(bus.vuad_array_rd_data_c1), 32'h2000000);
      check("inj_verr", 32'(bus.valid_par_err_c1), 32'd1);
      check("inj_derr", 32'(bus.dirty_par_err_c1), 32'd0);
      bus.rd_en_c0 = 1'b0;
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
